// File: rtl/complex_mult_seq_if.sv
// Operand/result handshake bundle for complex_mult_seq.
// The master side supplies operands and consumes results; the slave side is the multiplier.
interface complex_mult_seq_if #(
    parameter int WDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [WDTH-1:0] a_re;
    logic signed [WDTH-1:0] a_im;
    logic signed [WDTH-1:0] b_re;
    logic signed [WDTH-1:0] b_im;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [WDTH-1:0] out_re;
    logic signed [WDTH-1:0] out_im;
    logic                   out_ovf;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_ovf
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_ovf
    );
endinterface

// File: rtl/complex_mult_seq.sv
// Sequential complex multiplier: one shared Q1.(WDTH-1) real multiplier issues the
// four partial products serially and a one-deep output register holds the result.

module multiply #(
    parameter int WDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [WDTH-1:0] x,
    input  logic signed [WDTH-1:0] y,
    output logic signed [WDTH-1:0] z
);
    logic signed [2*WDTH-1:0] prod;

    assign prod = x * y;

    // Truncating arithmetic shift; -1 * -1 wraps back to -1 by design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= '0;
        end else begin
            z <= WDTH'(prod >>> (WDTH - 1));
        end
    end
endmodule

module complex_mult_seq #(
    parameter int WDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    complex_mult_seq_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]             state_reg, state_next;
    logic [1:0]             k_reg, k_next;
    logic signed [WDTH-1:0] a_re_reg, a_im_reg, b_re_reg, b_im_reg;
    logic signed [WDTH-1:0] re_acc_reg, im_acc_reg;
    logic                   re_ovf_reg;
    logic signed [WDTH-1:0] out_re_reg, out_im_reg;
    logic                   out_ovf_reg, out_valid_reg;

    logic signed [WDTH-1:0] op_x [4];
    logic signed [WDTH-1:0] op_y [4];
    logic signed [WDTH-1:0] mult_x, mult_y, mult_z;
    logic                   mult_rst_n;
    logic signed [WDTH-1:0] re_diff, im_sum;
    logic                   re_sub_ovf, im_add_ovf;
    logic                   accept;

    // Issue slot k pairs: (a_re,b_re), (a_im,b_im), (a_re,b_im), (a_im,b_re).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_issue
            assign op_x[gi] = (gi % 2 == 1) ? a_im_reg : a_re_reg;
            assign op_y[gi] = (gi == 1 || gi == 2) ? b_im_reg : b_re_reg;
        end
    endgenerate

    assign mult_x     = op_x[k_reg];
    assign mult_y     = op_y[k_reg];
    assign mult_rst_n = ~rst;

    multiply #(.WDTH(WDTH)) u_multiply (
        .clk   (clk),
        .rst_n (mult_rst_n),
        .x     (mult_x),
        .y     (mult_y),
        .z     (mult_z)
    );

    assign re_diff    = re_acc_reg - mult_z;
    assign im_sum     = im_acc_reg + mult_z;
    assign re_sub_ovf = (re_acc_reg[WDTH-1] != mult_z[WDTH-1]) &&
                        (re_diff[WDTH-1] != re_acc_reg[WDTH-1]);
    assign im_add_ovf = (im_acc_reg[WDTH-1] == mult_z[WDTH-1]) &&
                        (im_sum[WDTH-1] != im_acc_reg[WDTH-1]);

    assign accept = bus.in_valid && (state_reg == S_IDLE);

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ISSUE;
                    k_next     = 2'd0;
                end
            end
            S_ISSUE: begin
                k_next = k_reg + 2'd1;
                if (k_reg == 2'd3) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: state_next = S_HOLD;
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            k_reg         <= 2'd0;
            a_re_reg      <= '0;
            a_im_reg      <= '0;
            b_re_reg      <= '0;
            b_im_reg      <= '0;
            re_acc_reg    <= '0;
            im_acc_reg    <= '0;
            re_ovf_reg    <= 1'b0;
            out_re_reg    <= '0;
            out_im_reg    <= '0;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;

            if (accept) begin
                a_re_reg <= bus.a_re;
                a_im_reg <= bus.a_im;
                b_re_reg <= bus.b_re;
                b_im_reg <= bus.b_im;
            end

            // Product k lands on z while slot k+1 is issuing; only these slots sample z.
            if (state_reg == S_ISSUE) begin
                case (k_reg)
                    2'd1: re_acc_reg <= mult_z;
                    2'd2: begin
                        re_acc_reg <= re_diff;
                        re_ovf_reg <= re_sub_ovf;
                    end
                    2'd3: im_acc_reg <= mult_z;
                    default: ;
                endcase
            end

            if (state_reg == S_DRAIN) begin
                im_acc_reg    <= im_sum;
                out_re_reg    <= re_acc_reg;
                out_im_reg    <= im_sum;
                out_ovf_reg   <= re_ovf_reg | im_add_ovf;
                out_valid_reg <= 1'b1;
            end

            if ((state_reg == S_HOLD) && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state_reg == S_IDLE) && !rst;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_re    = out_re_reg;
    assign bus.out_im    = out_im_reg;
    assign bus.out_ovf   = out_ovf_reg;
endmodule
